// File: rtl/datapath_pkg.sv
// datapath_pkg: shared constants for the single-bus datapath.
//   WIDTH          - data/bus/register width
//   OP_*           - one-hot bit positions of the ALU operation select vector
//   C_FIELD_MSB / C_SIGN_BIT - immediate field IR[18:0] and its sign bit
//   sign_ext_c()   - sign-extends the IR immediate field to WIDTH bits
//   first_set16()  - index of the lowest set bit of a 16-bit vector
package datapath_pkg;

    localparam int WIDTH   = 32;
    localparam int NUM_OPS = 13;

    // Listed from highest to lowest priority.
    localparam int OP_AND  = 0;
    localparam int OP_OR   = 1;
    localparam int OP_ADD  = 2;
    localparam int OP_SUB  = 3;
    localparam int OP_MUL  = 4;
    localparam int OP_DIV  = 5;
    localparam int OP_SHR  = 6;
    localparam int OP_SHRA = 7;
    localparam int OP_SHL  = 8;
    localparam int OP_ROR  = 9;
    localparam int OP_ROL  = 10;
    localparam int OP_NEG  = 11;
    localparam int OP_NOT  = 12;

    localparam int C_FIELD_MSB = 18;
    localparam int C_SIGN_BIT  = 18;

    function automatic logic [WIDTH-1:0] sign_ext_c(input logic [WIDTH-1:0] ir);
        return {{(WIDTH-C_FIELD_MSB-1){ir[C_SIGN_BIT]}}, ir[C_FIELD_MSB:0]};
    endfunction

    // Scanning downward means the lowest-numbered set bit wins.
    function automatic logic [3:0] first_set16(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
            else      idx = idx;
        end
        return idx;
    endfunction

endpackage

// File: rtl/datapath_alu.sv
// datapath_alu: combinational ALU for the single-bus datapath.
//   i_a      - operand A (Y register)
//   i_b      - operand B (bus)
//   i_op     - one-hot op select, lowest index wins when several are set
//   o_result - 64-bit result {high, low}; zero when no op is selected
module datapath_alu
    import datapath_pkg::*;
(
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    input  logic [NUM_OPS-1:0] i_op,
    output logic [2*WIDTH-1:0] o_result
);

    logic [4:0]         w_sh;
    logic [2*WIDTH-1:0] w_mul;
    logic [2*WIDTH-1:0] w_ror2;
    logic [2*WIDTH-1:0] w_rol2;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;

    assign w_sh   = i_b[4:0];
    assign w_mul  = $signed({{WIDTH{i_a[WIDTH-1]}}, i_a}) * $signed({{WIDTH{i_b[WIDTH-1]}}, i_b});
    // Rotates via a doubled copy of A so a shift amount of 0 needs no special case.
    assign w_ror2 = {i_a, i_a} >> w_sh;
    assign w_rol2 = {i_a, i_a} << w_sh;

    // Signed divide; the zero-divisor case is handled in the op mux below.
    always_comb begin
        w_quot = 32'h0;
        w_rem  = 32'h0;
        if (i_b != 32'h0) begin
            w_quot = $signed(i_a) / $signed(i_b);
            w_rem  = $signed(i_a) % $signed(i_b);
        end else begin
            w_quot = 32'h0;
            w_rem  = 32'h0;
        end
    end

    // Priority op mux.
    always_comb begin
        o_result = 64'h0;
        if      (i_op[OP_AND])  o_result = {32'h0, i_a & i_b};
        else if (i_op[OP_OR])   o_result = {32'h0, i_a | i_b};
        else if (i_op[OP_ADD])  o_result = {32'h0, i_a + i_b};
        else if (i_op[OP_SUB])  o_result = {32'h0, i_a - i_b};
        else if (i_op[OP_MUL])  o_result = w_mul;
        else if (i_op[OP_DIV])  o_result = (i_b == 32'h0) ? {i_a, 32'hFFFF_FFFF} : {w_rem, w_quot};
        else if (i_op[OP_SHR])  o_result = {32'h0, i_a >> w_sh};
        else if (i_op[OP_SHRA]) o_result = {32'h0, $signed(i_a) >>> w_sh};
        else if (i_op[OP_SHL])  o_result = {32'h0, i_a << w_sh};
        else if (i_op[OP_ROR])  o_result = {32'h0, w_ror2[WIDTH-1:0]};
        else if (i_op[OP_ROL])  o_result = {32'h0, w_rol2[2*WIDTH-1:WIDTH]};
        else if (i_op[OP_NEG])  o_result = {32'h0, 32'h0 - i_b};
        else if (i_op[OP_NOT])  o_result = {32'h0, ~i_b};
        else                    o_result = 64'h0;
    end

endmodule

// File: rtl/datapath.sv
// datapath: 32-bit single-bus CPU datapath (R0-R15, HI, LO, PC, IR, MAR, MDR,
// Y, 64-bit Z, ALU). All transfers are driven by one-hot strobes.
//   clk, reset          - rising-edge clock, async active-low reset
//   R*out..MARout,INout,Cout - bus drive strobes (fixed priority)
//   R*in..MDRin         - register load enables (load bus on rising clk)
//   Read                - MDR source: 1 = IN port, 0 = bus
//   IncPC               - with PCin, increment PC instead of loading bus
//   AND..NOT            - ALU op selects
//   IN                  - external input word
//   BusMuxOut, PC       - observation outputs
module datapath #(
    parameter int WIDTH = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
    input  logic R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
    input  logic HIout, LOout, Zhighout, Zlowout, PCout, IRout, MDRout, MARout, Yout,
    input  logic INout,
    input  logic Cout,
    input  logic Read,
    input  logic IncPC,
    input  logic AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT,
    input  logic R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
    input  logic R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
    input  logic HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin,
    input  logic [WIDTH-1:0] IN,
    output logic [WIDTH-1:0] BusMuxOut,
    output logic [WIDTH-1:0] PC
);
    import datapath_pkg::*;

    logic [WIDTH-1:0]   r_gpr [16];
    logic [WIDTH-1:0]   r_hi, r_lo, r_pc, r_ir, r_mar, r_mdr, r_y;
    logic [2*WIDTH-1:0] r_z;

    logic [15:0]        w_rout, w_rin;
    logic [NUM_OPS-1:0] w_op;
    logic [WIDTH-1:0]   w_bus;
    logic [2*WIDTH-1:0] w_alu;

    assign w_rout = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                     R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};
    assign w_rin  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                     R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};
    assign w_op   = {NOT, NEG, ROL, ROR, SHL, SHRA, SHR, DIV, MUL, SUB, ADD, OR, AND};

    // Bus source mux: GPRs first (lowest index wins), then the fixed chain.
    always_comb begin
        w_bus = 32'h0;
        if      (|w_rout)  w_bus = r_gpr[first_set16(w_rout)];
        else if (HIout)    w_bus = r_hi;
        else if (LOout)    w_bus = r_lo;
        else if (Zhighout) w_bus = r_z[2*WIDTH-1:WIDTH];
        else if (Zlowout)  w_bus = r_z[WIDTH-1:0];
        else if (PCout)    w_bus = r_pc;
        else if (IRout)    w_bus = r_ir;
        else if (MDRout)   w_bus = r_mdr;
        else if (INout)    w_bus = IN;
        else if (Cout)     w_bus = sign_ext_c(r_ir);
        else if (Yout)     w_bus = r_y;
        else if (MARout)   w_bus = r_mar;
        else               w_bus = 32'h0;
    end

    datapath_alu u_alu (
        .i_a      (r_y),
        .i_b      (w_bus),
        .i_op     (w_op),
        .o_result (w_alu)
    );

    // General-purpose register file loads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) r_gpr[i] <= 32'h0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (w_rin[i]) r_gpr[i] <= w_bus;
            end
        end
    end

    // Special registers: HI, LO, IR, MAR, Y, MDR, PC, Z.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hi  <= 32'h0;
            r_lo  <= 32'h0;
            r_ir  <= 32'h0;
            r_mar <= 32'h0;
            r_y   <= 32'h0;
            r_mdr <= 32'h0;
            r_pc  <= 32'h0;
            r_z   <= 64'h0;
        end else begin
            if (HIin)  r_hi  <= w_bus;
            if (LOin)  r_lo  <= w_bus;
            if (IRin)  r_ir  <= w_bus;
            if (MARin) r_mar <= w_bus;
            if (Yin)   r_y   <= w_bus;
            if (MDRin) r_mdr <= Read ? IN : w_bus;
            if (PCin)  r_pc  <= IncPC ? (r_pc + 32'd1) : w_bus;
            if (Zin)   r_z   <= w_alu;
        end
    end

    assign BusMuxOut = w_bus;
    assign PC        = r_pc;

endmodule

// File: tb/tb_datapath.sv
module tb_datapath;
    import datapath_pkg::*;

    logic        clk;
    logic        reset;
    logic [15:0] rout, rin;
    logic [NUM_OPS-1:0] op;
    logic HIout, LOout, Zhighout, Zlowout, PCout, IRout, MDRout, MARout, Yout, INout, Cout;
    logic Read, IncPC;
    logic HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin;
    logic [31:0] IN;
    logic [31:0] BusMuxOut, PC;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] sb_q [$];

    datapath #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .R0out(rout[0]), .R1out(rout[1]), .R2out(rout[2]), .R3out(rout[3]),
        .R4out(rout[4]), .R5out(rout[5]), .R6out(rout[6]), .R7out(rout[7]),
        .R8out(rout[8]), .R9out(rout[9]), .R10out(rout[10]), .R11out(rout[11]),
        .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
        .HIout(HIout), .LOout(LOout), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .PCout(PCout), .IRout(IRout), .MDRout(MDRout), .MARout(MARout), .Yout(Yout),
        .INout(INout), .Cout(Cout), .Read(Read), .IncPC(IncPC),
        .AND(op[OP_AND]), .OR(op[OP_OR]), .ADD(op[OP_ADD]), .SUB(op[OP_SUB]),
        .MUL(op[OP_MUL]), .DIV(op[OP_DIV]), .SHR(op[OP_SHR]), .SHRA(op[OP_SHRA]),
        .SHL(op[OP_SHL]), .ROR(op[OP_ROR]), .ROL(op[OP_ROL]), .NEG(op[OP_NEG]),
        .NOT(op[OP_NOT]),
        .R0in(rin[0]), .R1in(rin[1]), .R2in(rin[2]), .R3in(rin[3]),
        .R4in(rin[4]), .R5in(rin[5]), .R6in(rin[6]), .R7in(rin[7]),
        .R8in(rin[8]), .R9in(rin[9]), .R10in(rin[10]), .R11in(rin[11]),
        .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
        .HIin(HIin), .LOin(LOin), .PCin(PCin), .IRin(IRin), .Zin(Zin), .Yin(Yin),
        .MARin(MARin), .MDRin(MDRin),
        .IN(IN), .BusMuxOut(BusMuxOut), .PC(PC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input logic [31:0] exp);
        sb_q.push_back(exp);
    endtask

    task automatic sb_check(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: scoreboard empty, got 0x%08h", tag, obs);
        end else begin
            exp = sb_q.pop_front();
            check_val(tag, obs, exp);
        end
    endtask

    task automatic clr_all();
        rout = 16'h0; rin = 16'h0; op = 13'h0;
        HIout = 1'b0; LOout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0; PCout = 1'b0;
        IRout = 1'b0; MDRout = 1'b0; MARout = 1'b0; Yout = 1'b0; INout = 1'b0; Cout = 1'b0;
        Read = 1'b0; IncPC = 1'b0;
        HIin = 1'b0; LOin = 1'b0; PCin = 1'b0; IRin = 1'b0; Zin = 1'b0; Yin = 1'b0;
        MARin = 1'b0; MDRin = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clr_all();
    endtask

    // IN -> MDR in one cycle.
    task automatic load_mdr(input logic [31:0] v);
        IN = v; Read = 1'b1; MDRin = 1'b1;
        tick();
    endtask

    task automatic load_gpr(input int idx, input logic [31:0] v);
        load_mdr(v);
        MDRout = 1'b1; rin[idx] = 1'b1;
        tick();
    endtask

    task automatic read_z(input string tag);
        Zlowout = 1'b1; #1; sb_check({tag, "_lo"}, BusMuxOut); Zlowout = 1'b0;
        Zhighout = 1'b1; #1; sb_check({tag, "_hi"}, BusMuxOut); Zhighout = 1'b0;
    endtask

    // Y <= a, then Z <= ALU(Y, b) with op bit opb; expected Z pushed up front.
    task automatic alu_run(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input int opb, input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        sb_push(exp_lo);
        sb_push(exp_hi);
        load_mdr(a);
        MDRout = 1'b1; Yin = 1'b1;
        tick();
        load_mdr(b);
        MDRout = 1'b1; op[opb] = 1'b1; Zin = 1'b1;
        tick();
        read_z(tag);
    endtask

    initial begin
        clr_all();
        IN = 32'h0;
        reset = 1'b0;
        #22;
        reset = 1'b1;
        @(negedge clk);

        // Reset state
        sb_push(32'h0); #1; sb_check("rst_bus", BusMuxOut);
        sb_push(32'h0); sb_check("rst_pc", PC);
        sb_push(32'h0); rout[3] = 1'b1; #1; sb_check("rst_r3", BusMuxOut); rout[3] = 1'b0;
        sb_push(32'h0); sb_push(32'h0); read_z("rst_z");
        rin[3] = 1'b1;
        tick();
        sb_push(32'h0); rout[3] = 1'b1; #1; sb_check("r3_idle_bus", BusMuxOut); rout[3] = 1'b0;

        // OR sequence
        load_gpr(3, 32'h22);
        load_gpr(7, 32'h24);
        load_gpr(4, 32'h28);
        sb_push(32'h28); rout[4] = 1'b1; #1; sb_check("r4_init", BusMuxOut); rout[4] = 1'b0;
        // Bus priority: R3 beats R7
        sb_push(32'h22); rout[3] = 1'b1; rout[7] = 1'b1; #1; sb_check("bus_prio", BusMuxOut);
        rout = 16'h0;

        sb_push(32'h1); sb_push(32'h321B8000); sb_push(32'h0);
        IN = 32'h321B8000; IncPC = 1'b1; PCin = 1'b1; MARin = 1'b1; MDRin = 1'b1; Read = 1'b1;
        tick();
        sb_check("t0_pc", PC);
        MDRout = 1'b1; #1; sb_check("t0_mdr", BusMuxOut); MDRout = 1'b0;
        MARout = 1'b1; #1; sb_check("t0_mar", BusMuxOut); MARout = 1'b0;

        sb_push(32'h321B8000);
        MDRout = 1'b1; IRin = 1'b1;
        tick();
        IRout = 1'b1; #1; sb_check("t1_ir", BusMuxOut); IRout = 1'b0;

        sb_push(32'h22);
        rout[3] = 1'b1; Yin = 1'b1;
        tick();
        Yout = 1'b1; #1; sb_check("t2_y", BusMuxOut); Yout = 1'b0;

        sb_push(32'h26); sb_push(32'h0);
        rout[7] = 1'b1; op[OP_OR] = 1'b1; Zin = 1'b1;
        tick();
        read_z("t3_z");

        sb_push(32'h26); sb_push(32'h26);
        Zlowout = 1'b1; rin[4] = 1'b1; #1;
        sb_check("t4_bus", BusMuxOut);
        tick();
        rout[4] = 1'b1; #1; sb_check("t4_r4", BusMuxOut); rout[4] = 1'b0;

        // Arithmetic and shift checks
        alu_run("add_wrap", 32'hFFFFFFFF, 32'h1, OP_ADD, 32'h0, 32'h0);
        alu_run("sub_wrap", 32'h0, 32'h1, OP_SUB, 32'hFFFFFFFF, 32'h0);
        alu_run("mul_neg", 32'hFFFFFFFD, 32'h5, OP_MUL, 32'hFFFFFFF1, 32'hFFFFFFFF);
        alu_run("div_neg", 32'hFFFFFFF9, 32'h2, OP_DIV, 32'hFFFFFFFD, 32'hFFFFFFFF);
        alu_run("div_zero", 32'h9, 32'h0, OP_DIV, 32'hFFFFFFFF, 32'h9);
        alu_run("shr", 32'h80000001, 32'h1, OP_SHR, 32'h40000000, 32'h0);
        alu_run("shra", 32'h80000001, 32'h1, OP_SHRA, 32'hC0000000, 32'h0);
        alu_run("shl", 32'h80000001, 32'h1, OP_SHL, 32'h00000002, 32'h0);
        alu_run("ror", 32'h80000001, 32'h1, OP_ROR, 32'hC0000000, 32'h0);
        alu_run("rol", 32'h80000001, 32'h1, OP_ROL, 32'h00000003, 32'h0);
        alu_run("neg", 32'h0, 32'h5, OP_NEG, 32'hFFFFFFFB, 32'h0);
        alu_run("not", 32'h0, 32'h0F0F0F0F, OP_NOT, 32'hF0F0F0F0, 32'h0);
        alu_run("and", 32'hFF00FF00, 32'h0FF00FF0, OP_AND, 32'h0F000F00, 32'h0);

        // Op priority: AND wins over ADD; no op with Zin clears Z
        sb_push(32'h00000004); sb_push(32'h0);
        load_mdr(32'h6); MDRout = 1'b1; Yin = 1'b1; tick();
        load_mdr(32'hC); MDRout = 1'b1; op[OP_AND] = 1'b1; op[OP_ADD] = 1'b1; Zin = 1'b1; tick();
        read_z("op_prio");
        sb_push(32'h0); sb_push(32'h0);
        MDRout = 1'b1; Zin = 1'b1; tick();
        read_z("no_op");

        // PC load and wrap
        sb_push(32'hFFFFFFFF); sb_push(32'h0);
        load_mdr(32'hFFFFFFFF); MDRout = 1'b1; PCin = 1'b1; tick();
        sb_check("pc_load", PC);
        IncPC = 1'b1; PCin = 1'b1; tick();
        sb_check("pc_wrap", PC);

        // Cout sign extension
        sb_push(32'hFFFC0000); sb_push(32'h0003FFFF);
        load_mdr(32'h00040000); MDRout = 1'b1; IRin = 1'b1; tick();
        Cout = 1'b1; #1; sb_check("cout_neg", BusMuxOut); Cout = 1'b0;
        load_mdr(32'hFFFBFFFF); MDRout = 1'b1; IRin = 1'b1; tick();
        Cout = 1'b1; #1; sb_check("cout_pos", BusMuxOut); Cout = 1'b0;

        // Asynchronous reset mid-cycle
        load_gpr(3, 32'h5A5A5A5A);
        IncPC = 1'b1; PCin = 1'b1; tick();
        sb_push(32'h1); sb_check("pre_rst_pc", PC);
        sb_push(32'h0); sb_push(32'h0); sb_push(32'h0); sb_push(32'h0);
        #2;
        rout[3] = 1'b1;
        reset = 1'b0;
        #1;
        sb_check("arst_r3", BusMuxOut); rout[3] = 1'b0;
        sb_check("arst_pc", PC);
        MDRout = 1'b1; #1; sb_check("arst_mdr", BusMuxOut); MDRout = 1'b0;
        IRout = 1'b1; #1; sb_check("arst_ir", BusMuxOut); IRout = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tick();

        if (sb_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_leftover: %0d entries remain, expected 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/datapath.md
Name: datapath

Overview:
- 32-bit single-bus CPU datapath: 16 GPRs R0–R15, HI, LO, PC, IR, MAR, MDR, Y, 64-bit Z and an ALU, all around one shared bus.
- Every register load, bus drive and ALU operation is a one-hot control strobe from an external control unit or bench.
- BusMuxOut and PC are exported for observation.

Parameters:
- WIDTH, 32, data/bus/register width (only 32 is required).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; clears all registers.
- R0out..R15out  in  1 each  drive Rn onto the bus.
- HIout, LOout, Zhighout, Zlowout, PCout, IRout, MDRout, MARout, Yout  in  1 each  drive the named register onto the bus.
- INout  in  1  drive the IN port onto the bus.
- Cout  in  1  drive sign-extended IR[18:0] onto the bus.
- Read  in  1  MDR input select: 1 = IN port, 0 = bus.
- IncPC  in  1  with PCin, PC <= PC+1.
- AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT  in  1 each  ALU operation select.
- R0in..R15in, HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin  in  1 each  load enables.
- IN  in  32  external memory-data / input word.
- BusMuxOut  out  32  current bus value (combinational).
- PC  out  32  program counter.

Behaviour:
- Reset (reset=0, asynchronous): every register goes to 0, including Z (64 bits). Reset overrides all load enables.
- Bus:
  - Combinational.
  - If several out strobes are active, priority is R0..R15, HI, LO, Zhigh, Zlow, PC, IR, MDR, IN, C, Y, MAR.
  - With no out strobe active, the bus is 0.
- Register loads: on rising clk, any register whose Xin=1 loads the bus value. Zero-cycle bus, one-cycle load latency.
- MDR: D = Read ? IN : BusMuxOut; loads when MDRin=1.
- PC:
  - PCin & IncPC gives PC+1, wrapping mod 2^32.
  - PCin alone loads the bus.
- ALU:
  - A = Y, B = BusMuxOut; combinational; result is written to Z only on a clock edge with Zin=1.
  - Op priority if more than one is active: the port order listed above.
  - If no op is active while Zin=1, Z <= 0.
- ALU results (Zhigh = 0 unless stated):
  - AND, OR: bitwise.
  - ADD, SUB: A±B mod 2^32.
  - MUL: signed 64-bit product {Zhigh,Zlow}.
  - DIV: signed; Zlow = quotient truncated toward zero, Zhigh = remainder.
  - DIV with B=0: Zlow = 0xFFFFFFFF, Zhigh = A.
  - SHR/SHRA/SHL: A shifted by B[4:0], logical/arithmetic/logical.
  - ROR/ROL: A rotated by B[4:0].
  - NEG: −B. NOT: ~B.
- Simultaneous events: a register may load on the same edge it drives the bus, taking the pre-edge value.
- Reset mid-operation discards all state; there are no pending operations.

Decomposition:
- Shared package holds:
  - the ALU op one-hot bit indices;
  - WIDTH;
  - C-sign-extension field constants: IR[18:0], sign bit 18.
- One sub-module, datapath_alu: combinational, A/B/op in, 64-bit result out.
- Registers and the bus mux stay in datapath.

Test Plan:
- Reset then release: all registers are 0, BusMuxOut=0, PC=0. Assert R3in with nothing driving the bus: R3 stays 0.
- OR sequence:
  - IN=0x22 Read+MDRin, then MDRout+R3in; R7 loaded with 0x24 the same way; R4 loaded with 0x28.
  - T0: IncPC+PCin+MARin+MDRin+Read, IN=0x321B8000 → PC=1, MDR=0x321B8000.
  - T1: MDRout+IRin → IR=0x321B8000.
  - T2: R3out+Yin → Y=0x22.
  - T3: R7out+OR+Zin → Zlow=0x26.
  - T4: Zlowout+R4in → R4=0x26, BusMuxOut=0x26 during T4.
- ADD/SUB wrap:
  - Y=0xFFFFFFFF, B=1, ADD → Zlow=0.
  - Y=0, B=1, SUB → Zlow=0xFFFFFFFF, Zhigh=0.
- MUL/DIV:
  - Y=−3, B=5, MUL → {Zhigh,Zlow}=0xFFFFFFFF_FFFFFFF1.
  - Y=−7, B=2, DIV → Zlow=−3, Zhigh=−1.
  - Y=9, B=0, DIV → Zlow=0xFFFFFFFF, Zhigh=9.
- Shifts/rotates, with Y=0x80000001, B=1:
  - SHR → 0x40000000.
  - SHRA → 0xC0000000.
  - SHL → 0x00000002.
  - ROR → 0xC0000000.
  - ROL → 0x00000003.
- Cout/NEG/async reset:
  - IR=0x00040000, Cout → bus = 0xFFFC0000.
  - NEG with B=5 → 0xFFFFFFFB.
  - Drop reset mid-cycle → all registers are 0 immediately, before the next edge.
